// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (port A)
// and the debug/boot port (port B); waits out read latency and drives the CPU stall.
module data_mem_arbiter #(
  parameter int unsigned AW     = 19,
  parameter int unsigned DW     = 19,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          cpu_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(RD_LAT - 1);

  typedef enum logic {StIdle, StRdWait} state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;      // 1: B wins a tie
  logic            owner_q, owner_d;  // 1: B owns the outstanding read
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   a_rdata_q, b_rdata_q;

  logic gnt_a, gnt_b, issue, issue_we, rd_done;

  // Grants are suppressed while reset is asserted so every output reads 0.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == StIdle && !reset) begin
      if (a_req && b_req) begin
        gnt_b = ptr_q;
        gnt_a = ~ptr_q;
      end else begin
        gnt_a = a_req;
        gnt_b = b_req;
      end
    end
  end

  assign issue    = gnt_a | gnt_b;
  assign issue_we = gnt_b ? b_we : a_we;
  assign rd_done  = (state_q == StRdWait) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          ptr_d = gnt_a;
          if (!issue_we) begin
            state_d = StRdWait;
            owner_d = gnt_b;
            cnt_d   = CntLoad;
          end
        end
      end
      StRdWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_gnt     = gnt_a;
    b_gnt     = gnt_b;
    mem_write = issue & issue_we;
    mem_read  = issue & ~issue_we;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (gnt_b) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end else if (gnt_a) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end
    a_rvalid  = rd_done & ~owner_q;
    b_rvalid  = rd_done & owner_q;
    // Read data is forwarded in the rvalid cycle, then held in the per-port register.
    a_rdata   = a_rvalid ? mem_rdata : a_rdata_q;
    b_rdata   = b_rvalid ? mem_rdata : b_rdata_q;
    cpu_stall = ~reset & ((a_req & ~gnt_a & ~a_rvalid) |
                          ((state_q == StRdWait) & ~owner_q & ~a_rvalid));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      addr_q    <= mem_addr;
      wdata_q   <= mem_wdata;
      a_rdata_q <= a_rdata;
      b_rdata_q <= b_rdata;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 19-bit data memory between two requesters: the CPU load/store path (port A) and the debug/boot-loader port (port B).
- Sits between the datapath/control unit and the data memory.
- Sequences each access with req/gnt handshakes and waits out the read latency.
- Uses round-robin priority so neither port starves, and produces a CPU stall.

Parameters:
- AW, 19, address width.
- DW, 19, data width.
- RD_LAT, 1, cycles from memory read strobe to valid memory read data (legal range 1..4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_req  input  1  port A (CPU) access request.
- a_we  input  1  port A: 1 = write, 0 = read.
- a_addr  input  AW  port A address.
- a_wdata  input  DW  port A write data.
- a_gnt  output  1  port A grant pulse (command issued this cycle).
- a_rvalid  output  1  port A read data valid pulse.
- a_rdata  output  DW  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the port A signals, for port B (debug).
- cpu_stall  output  1  high when a_req is high and A has no grant and no rvalid this cycle.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; valid RD_LAT cycles after mem_read.

Behaviour:
- **Reset:** all outputs 0. FSM = IDLE. Priority pointer = A. Latency counter = 0. Owner register = A.
- **FSM states:** IDLE, RD_WAIT.
- **IDLE, arbitration:**
  - If only one req is high, grant it.
  - If both are high, grant the port that was not granted last (pointer).
- **IDLE, grant cycle (combinational from registered state, same cycle as req):**
  - x_gnt=1.
  - mem_addr/mem_wdata = the granted port's addr/wdata.
  - mem_write = we; mem_read = ~we.
  - Pointer flips to the other port.
- **Writes:** complete in the grant cycle; FSM stays IDLE, so back-to-back writes are allowed (1 per cycle).
- **Reads:**
  - FSM goes to RD_WAIT; owner is latched; counter loads RD_LAT-1.
  - In RD_WAIT the counter decrements each cycle.
  - When the counter is 0: x_rdata <= mem_rdata and x_rvalid=1 for exactly one cycle for the owner, then return to IDLE.
  - Minimum read turnaround is RD_LAT+1 cycles, grant to next grant.
- **RD_WAIT:** no grants, mem_read=mem_write=0, mem_addr holds its last value. Requests stay pending.
- **rdata hold:** x_rdata holds its last read value until the next read for that port. The rdata of the non-owner is unchanged.
- **Requester rules:** hold req/we/addr/wdata stable until gnt is seen. Deassert or change them in the cycle after gnt.
  - A req dropped before gnt is legal; no access is issued.
- **Single requester:** a single port requesting continuously is granted every eligible cycle; the pointer does not block it.
- **cpu_stall** = a_req & ~a_gnt, plus high through RD_WAIT while A owns the read until a_rvalid.
- **Reset mid-read:** the FSM aborts to IDLE, no rvalid is issued, and the pending read is dropped.
- **Address/data width:** passed through unchanged; no arithmetic.

Test Plan:
- Reset, then a_req=1, a_we=1, a_addr=0x00010, a_wdata=0x7FFFF for 1 cycle -> a_gnt=1, mem_write=1, mem_addr=0x00010, mem_wdata=0x7FFFF in the same cycle; cpu_stall=0.
- RD_LAT=1: after a write of 0x12345 to 0x00020, a_req read of 0x00020 -> a_gnt in cycle N, a_rvalid and a_rdata=0x12345 in N+1, mem_read low in N+1; next grant no earlier than N+2.
- a_req and b_req held high together as writes for 4 cycles from reset -> grants A, B, A, B in consecutive cycles; mem_addr alternates between a_addr and b_addr.
- RD_LAT=3: b read granted at N, a_req rises at N+1 -> a_gnt=0 and cpu_stall=1 for N+1..N+3; b_rvalid at N+3; a_gnt at N+4.
- Assert reset at N+1 of an RD_LAT=3 read -> no rvalid is seen; all outputs 0; after release, a_req is granted on the first cycle.
- b_req alone held for 5 write cycles -> b_gnt=1 every cycle; a_gnt=0; cpu_stall=0.
